// File: rtl/pyrm_reg_file_block_if.sv
// Handshake bundle for the register file: write-back address/data, decode
// claims, and two read ports (request plus registered response).
interface pyrm_reg_file_block_if;
    logic [63:0] wr_addr_pyri;
    logic        wr_addr_valid_pyri;
    logic        wr_addr_retry_pyro;
    logic [63:0] wr_data_pyri;
    logic        wr_data_valid_pyri;
    logic        wr_data_retry_pyro;
    logic [4:0]  claim_addr_pyri;
    logic        claim_valid_pyri;
    logic        claim_retry_pyro;
    logic [4:0]  rs1_addr_pyri;
    logic        rs1_valid_pyri;
    logic        rs1_retry_pyro;
    logic [63:0] rs1_data_pyro;
    logic        rs1_data_valid_pyro;
    logic        rs1_data_retry_pyri;
    logic [4:0]  rs2_addr_pyri;
    logic        rs2_valid_pyri;
    logic        rs2_retry_pyro;
    logic [63:0] rs2_data_pyro;
    logic        rs2_data_valid_pyro;
    logic        rs2_data_retry_pyri;

    modport master (
        output wr_addr_pyri, wr_addr_valid_pyri, wr_data_pyri, wr_data_valid_pyri,
        output claim_addr_pyri, claim_valid_pyri,
        output rs1_addr_pyri, rs1_valid_pyri, rs1_data_retry_pyri,
        output rs2_addr_pyri, rs2_valid_pyri, rs2_data_retry_pyri,
        input  wr_addr_retry_pyro, wr_data_retry_pyro, claim_retry_pyro,
        input  rs1_retry_pyro, rs1_data_pyro, rs1_data_valid_pyro,
        input  rs2_retry_pyro, rs2_data_pyro, rs2_data_valid_pyro
    );

    modport slave (
        input  wr_addr_pyri, wr_addr_valid_pyri, wr_data_pyri, wr_data_valid_pyri,
        input  claim_addr_pyri, claim_valid_pyri,
        input  rs1_addr_pyri, rs1_valid_pyri, rs1_data_retry_pyri,
        input  rs2_addr_pyri, rs2_valid_pyri, rs2_data_retry_pyri,
        output wr_addr_retry_pyro, wr_data_retry_pyro, claim_retry_pyro,
        output rs1_retry_pyro, rs1_data_pyro, rs1_data_valid_pyro,
        output rs2_retry_pyro, rs2_data_pyro, rs2_data_valid_pyro
    );
endinterface

// File: rtl/pyrm_reg_file_block.sv
// 32x64 register file with write address/data pairing buffers, a busy-bit
// scoreboard for claimed destinations, and two bypassing read ports with
// registered, back-pressurable responses. x0 always reads as zero.
module pyrm_reg_file_block (
    input  logic                        clk,
    input  logic                        reset_pyri,
    pyrm_reg_file_block_if.slave        bus
);
    logic [63:0] regs_r [32];
    logic [31:0] busy_r;
    logic        addr_buf_valid_r;
    logic [4:0]  addr_buf_r;
    logic        data_buf_valid_r;
    logic [63:0] data_buf_r;
    logic [63:0] rs1_data_r;
    logic        rs1_data_valid_r;
    logic [63:0] rs2_data_r;
    logic        rs2_data_valid_r;

    logic [4:0]  wr_idx_in_s;
    logic        unused_addr_bits_s;
    logic        addr_retry_s;
    logic        data_retry_s;
    logic        addr_xfer_s;
    logic        data_xfer_s;
    logic        commit_s;
    logic [4:0]  commit_idx_s;
    logic [63:0] commit_data_s;
    logic        claim_retry_s;
    logic        claim_xfer_s;
    logic [31:0] busy_nxt_s;
    logic        rs1_bypass_s;
    logic        rs1_retry_s;
    logic        rs1_accept_s;
    logic [63:0] rs1_rdata_s;
    logic        rs2_bypass_s;
    logic        rs2_retry_s;
    logic        rs2_accept_s;
    logic [63:0] rs2_rdata_s;

    // Only the low five address bits select a register; the rest are folded away.
    assign wr_idx_in_s        = bus.wr_addr_pyri[4:0];
    assign unused_addr_bits_s = ^bus.wr_addr_pyri[63:5];

    // Handshakes, write pairing, scoreboard update and read selection.
    // At most one pairing buffer is ever full, so each retry only needs the
    // other side's buffer state and incoming valid (no combinational loop).
    always_comb begin
        addr_retry_s  = ~reset_pyri & addr_buf_valid_r & ~data_buf_valid_r & ~bus.wr_data_valid_pyri;
        data_retry_s  = ~reset_pyri & data_buf_valid_r & ~addr_buf_valid_r & ~bus.wr_addr_valid_pyri;
        addr_xfer_s   = bus.wr_addr_valid_pyri & ~addr_retry_s;
        data_xfer_s   = bus.wr_data_valid_pyri & ~data_retry_s;
        commit_s      = (addr_buf_valid_r | addr_xfer_s) & (data_buf_valid_r | data_xfer_s);
        commit_idx_s  = addr_buf_valid_r ? addr_buf_r : wr_idx_in_s;
        commit_data_s = data_buf_valid_r ? data_buf_r : bus.wr_data_pyri;

        claim_retry_s = ~reset_pyri & busy_r[bus.claim_addr_pyri]
                        & ~(commit_s & (commit_idx_s == bus.claim_addr_pyri));
        claim_xfer_s  = bus.claim_valid_pyri & ~claim_retry_s;

        // Commit clears first so a same-cycle claim of that register wins.
        busy_nxt_s = busy_r;
        if (commit_s) begin
            busy_nxt_s[commit_idx_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (claim_xfer_s) begin
            busy_nxt_s[bus.claim_addr_pyri] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;

        rs1_bypass_s = commit_s & (commit_idx_s == bus.rs1_addr_pyri);
        rs1_retry_s  = ~reset_pyri & ((busy_r[bus.rs1_addr_pyri] & ~rs1_bypass_s)
                                      | (rs1_data_valid_r & bus.rs1_data_retry_pyri));
        rs1_accept_s = bus.rs1_valid_pyri & ~rs1_retry_s;
        if (bus.rs1_addr_pyri == 5'd0) begin
            rs1_rdata_s = 64'd0;
        end else if (rs1_bypass_s) begin
            rs1_rdata_s = commit_data_s;
        end else begin
            rs1_rdata_s = regs_r[bus.rs1_addr_pyri];
        end

        rs2_bypass_s = commit_s & (commit_idx_s == bus.rs2_addr_pyri);
        rs2_retry_s  = ~reset_pyri & ((busy_r[bus.rs2_addr_pyri] & ~rs2_bypass_s)
                                      | (rs2_data_valid_r & bus.rs2_data_retry_pyri));
        rs2_accept_s = bus.rs2_valid_pyri & ~rs2_retry_s;
        if (bus.rs2_addr_pyri == 5'd0) begin
            rs2_rdata_s = 64'd0;
        end else if (rs2_bypass_s) begin
            rs2_rdata_s = commit_data_s;
        end else begin
            rs2_rdata_s = regs_r[bus.rs2_addr_pyri];
        end
    end

    // Address pairing buffer: holds an address waiting for its data.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            addr_buf_valid_r <= 1'b0;
            addr_buf_r       <= 5'd0;
        end else if (commit_s) begin
            if (addr_buf_valid_r && addr_xfer_s) begin
                addr_buf_r <= wr_idx_in_s;
            end
            addr_buf_valid_r <= addr_buf_valid_r & addr_xfer_s;
        end else if (addr_xfer_s) begin
            addr_buf_r       <= wr_idx_in_s;
            addr_buf_valid_r <= 1'b1;
        end
    end

    // Data pairing buffer: holds write data waiting for its address.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            data_buf_valid_r <= 1'b0;
            data_buf_r       <= 64'd0;
        end else if (commit_s) begin
            if (data_buf_valid_r && data_xfer_s) begin
                data_buf_r <= bus.wr_data_pyri;
            end
            data_buf_valid_r <= data_buf_valid_r & data_xfer_s;
        end else if (data_xfer_s) begin
            data_buf_r       <= bus.wr_data_pyri;
            data_buf_valid_r <= 1'b1;
        end
    end

    // Scoreboard of destinations claimed by decode but not yet written back.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Register array; writes to x0 are dropped.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 64'd0;
            end
        end else if (commit_s && (commit_idx_s != 5'd0)) begin
            regs_r[commit_idx_s] <= commit_data_s;
        end
    end

    // Source-1 response register: load on accept, hold while stalled.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            rs1_data_r       <= 64'd0;
            rs1_data_valid_r <= 1'b0;
        end else if (rs1_accept_s) begin
            rs1_data_r       <= rs1_rdata_s;
            rs1_data_valid_r <= 1'b1;
        end else if (!(rs1_data_valid_r && bus.rs1_data_retry_pyri)) begin
            rs1_data_valid_r <= 1'b0;
        end
    end

    // Source-2 response register: load on accept, hold while stalled.
    always_ff @(posedge clk or posedge reset_pyri) begin
        if (reset_pyri) begin
            rs2_data_r       <= 64'd0;
            rs2_data_valid_r <= 1'b0;
        end else if (rs2_accept_s) begin
            rs2_data_r       <= rs2_rdata_s;
            rs2_data_valid_r <= 1'b1;
        end else if (!(rs2_data_valid_r && bus.rs2_data_retry_pyri)) begin
            rs2_data_valid_r <= 1'b0;
        end
    end

    assign bus.wr_addr_retry_pyro  = addr_retry_s;
    assign bus.wr_data_retry_pyro  = data_retry_s;
    assign bus.claim_retry_pyro    = claim_retry_s;
    assign bus.rs1_retry_pyro      = rs1_retry_s;
    assign bus.rs1_data_pyro       = rs1_data_r;
    assign bus.rs1_data_valid_pyro = rs1_data_valid_r;
    assign bus.rs2_retry_pyro      = rs2_retry_s;
    assign bus.rs2_data_pyro       = rs2_data_r;
    assign bus.rs2_data_valid_pyro = rs2_data_valid_r;
endmodule

// File: tb/tb_pyrm_reg_file_block.sv
// Directed bench for pyrm_reg_file_block: inputs change 1 time unit after a
// rising edge, combinational retries are checked 1 unit later, registered
// responses are checked after the edge that loads them.
module tb_pyrm_reg_file_block;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    pyrm_reg_file_block_if bus ();

    pyrm_reg_file_block dut (
        .clk        (clk),
        .reset_pyri (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_addr_pyri        = 64'd0;
        bus.wr_addr_valid_pyri  = 1'b0;
        bus.wr_data_pyri        = 64'd0;
        bus.wr_data_valid_pyri  = 1'b0;
        bus.claim_addr_pyri     = 5'd0;
        bus.claim_valid_pyri    = 1'b0;
        bus.rs1_addr_pyri       = 5'd0;
        bus.rs1_valid_pyri      = 1'b0;
        bus.rs1_data_retry_pyri = 1'b0;
        bus.rs2_addr_pyri       = 5'd0;
        bus.rs2_valid_pyri      = 1'b0;
        bus.rs2_data_retry_pyri = 1'b0;
    endtask

    // Full rs1 read: request accepted, response checked, then consumed.
    task automatic rd1(input string tag, input logic [4:0] a, input logic [63:0] exp);
        bus.rs1_valid_pyri = 1'b1;
        bus.rs1_addr_pyri  = a;
        #1;
        chk({tag, "_retry"}, bus.rs1_retry_pyro, 64'd0);
        tick();
        bus.rs1_valid_pyri = 1'b0;
        chk({tag, "_valid"}, bus.rs1_data_valid_pyro, 64'd1);
        chk({tag, "_data"}, bus.rs1_data_pyro, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rs1_valid", bus.rs1_data_valid_pyro, 64'd0);
        chk("rst_rs1_data", bus.rs1_data_pyro, 64'd0);
        chk("rst_rs2_valid", bus.rs2_data_valid_pyro, 64'd0);
        chk("rst_rs2_data", bus.rs2_data_pyro, 64'd0);
        rst = 1'b0;
        tick();

        // Same-cycle addr+data commit, upper address bits ignored.
        bus.wr_addr_pyri       = 64'hABCD_0000_0000_0005;
        bus.wr_addr_valid_pyri = 1'b1;
        bus.wr_data_pyri       = 64'h0000_0000_DEAD_BEEF;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("a_addr_retry", bus.wr_addr_retry_pyro, 64'd0);
        chk("a_data_retry", bus.wr_data_retry_pyro, 64'd0);
        tick();
        idle();
        rd1("a_rd5", 5'd5, 64'h0000_0000_DEAD_BEEF);
        chk("a_consumed", bus.rs1_data_valid_pyro, 64'd0);

        // Address early, data three cycles later; second address retried meanwhile.
        bus.wr_addr_pyri       = 64'd7;
        bus.wr_addr_valid_pyri = 1'b1;
        #1;
        chk("b_addr_retry_c0", bus.wr_addr_retry_pyro, 64'd0);
        tick();
        bus.wr_addr_pyri = 64'd8;
        #1;
        chk("b_addr_retry_c1", bus.wr_addr_retry_pyro, 64'd1);
        tick();
        chk("b_addr_retry_c2", bus.wr_addr_retry_pyro, 64'd1);
        tick();
        bus.wr_data_pyri       = 64'h11;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("b_addr_retry_c3", bus.wr_addr_retry_pyro, 64'd0);
        chk("b_data_retry_c3", bus.wr_data_retry_pyro, 64'd0);
        tick();
        idle();
        rd1("b_rd7", 5'd7, 64'h11);
        bus.wr_data_pyri       = 64'h88;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("b_data_retry_x8", bus.wr_data_retry_pyro, 64'd0);
        tick();
        idle();
        rd1("b_rd8", 5'd8, 64'h88);

        // Claim x9, reads stall until write-back, bypass in the commit cycle.
        bus.claim_addr_pyri  = 5'd9;
        bus.claim_valid_pyri = 1'b1;
        #1;
        chk("c_claim_retry", bus.claim_retry_pyro, 64'd0);
        tick();
        idle();
        bus.rs2_addr_pyri  = 5'd9;
        bus.rs2_valid_pyri = 1'b1;
        #1;
        chk("c_rs2_retry_0", bus.rs2_retry_pyro, 64'd1);
        tick();
        chk("c_rs2_retry_1", bus.rs2_retry_pyro, 64'd1);
        chk("c_rs2_noresp", bus.rs2_data_valid_pyro, 64'd0);
        bus.wr_addr_pyri       = 64'd9;
        bus.wr_addr_valid_pyri = 1'b1;
        bus.wr_data_pyri       = 64'h42;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("c_rs2_bypass_retry", bus.rs2_retry_pyro, 64'd0);
        tick();
        idle();
        chk("c_rs2_valid", bus.rs2_data_valid_pyro, 64'd1);
        chk("c_rs2_data", bus.rs2_data_pyro, 64'h42);
        tick();
        rd1("c_rd9", 5'd9, 64'h42);

        // Claim and commit x3 in one cycle: data written, x3 stays busy.
        bus.claim_addr_pyri    = 5'd3;
        bus.claim_valid_pyri   = 1'b1;
        bus.wr_addr_pyri       = 64'd3;
        bus.wr_addr_valid_pyri = 1'b1;
        bus.wr_data_pyri       = 64'h5;
        bus.wr_data_valid_pyri = 1'b1;
        bus.rs2_addr_pyri      = 5'd3;
        bus.rs2_valid_pyri     = 1'b1;
        #1;
        chk("d_claim_retry", bus.claim_retry_pyro, 64'd0);
        chk("d_rs2_retry", bus.rs2_retry_pyro, 64'd0);
        tick();
        idle();
        chk("d_rs2_data", bus.rs2_data_pyro, 64'h5);
        bus.claim_addr_pyri  = 5'd3;
        bus.claim_valid_pyri = 1'b1;
        bus.rs1_addr_pyri    = 5'd3;
        bus.rs1_valid_pyri   = 1'b1;
        #1;
        chk("d_claim_busy", bus.claim_retry_pyro, 64'd1);
        chk("d_rs1_busy", bus.rs1_retry_pyro, 64'd1);
        tick();
        bus.claim_valid_pyri   = 1'b0;
        bus.wr_addr_pyri       = 64'd3;
        bus.wr_addr_valid_pyri = 1'b1;
        bus.wr_data_pyri       = 64'h33;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("d_rs1_bypass", bus.rs1_retry_pyro, 64'd0);
        tick();
        idle();
        chk("d_rs1_data", bus.rs1_data_pyro, 64'h33);
        tick();
        rd1("d_rd3", 5'd3, 64'h33);

        // x0: writes discarded, claims never stall, reads return zero.
        bus.wr_addr_pyri       = 64'd0;
        bus.wr_addr_valid_pyri = 1'b1;
        bus.wr_data_pyri       = 64'hFFFF;
        bus.wr_data_valid_pyri = 1'b1;
        bus.rs2_addr_pyri      = 5'd0;
        bus.rs2_valid_pyri     = 1'b1;
        #1;
        chk("e_rs2_retry", bus.rs2_retry_pyro, 64'd0);
        tick();
        idle();
        chk("e_rs2_data", bus.rs2_data_pyro, 64'd0);
        bus.claim_addr_pyri  = 5'd0;
        bus.claim_valid_pyri = 1'b1;
        #1;
        chk("e_claim0_a", bus.claim_retry_pyro, 64'd0);
        tick();
        bus.rs1_addr_pyri  = 5'd0;
        bus.rs1_valid_pyri = 1'b1;
        #1;
        chk("e_claim0_b", bus.claim_retry_pyro, 64'd0);
        chk("e_rs1_retry", bus.rs1_retry_pyro, 64'd0);
        tick();
        idle();
        chk("e_rs1_data", bus.rs1_data_pyro, 64'd0);
        tick();

        // Both ports read x5 together, then rs1 back-to-back with no bubble.
        bus.rs1_addr_pyri  = 5'd5;
        bus.rs1_valid_pyri = 1'b1;
        bus.rs2_addr_pyri  = 5'd5;
        bus.rs2_valid_pyri = 1'b1;
        #1;
        chk("f_rs2_retry", bus.rs2_retry_pyro, 64'd0);
        tick();
        bus.rs1_addr_pyri  = 5'd7;
        bus.rs2_valid_pyri = 1'b0;
        #1;
        chk("f_rs1_data", bus.rs1_data_pyro, 64'h0000_0000_DEAD_BEEF);
        chk("f_rs2_data", bus.rs2_data_pyro, 64'h0000_0000_DEAD_BEEF);
        chk("f_b2b_retry", bus.rs1_retry_pyro, 64'd0);
        tick();
        idle();
        chk("f_b2b_valid", bus.rs1_data_valid_pyro, 64'd1);
        chk("f_b2b_data", bus.rs1_data_pyro, 64'h11);
        tick();

        // Claim and read x5 in the same cycle: read gets the pre-claim value.
        bus.claim_addr_pyri  = 5'd5;
        bus.claim_valid_pyri = 1'b1;
        bus.rs1_addr_pyri    = 5'd5;
        bus.rs1_valid_pyri   = 1'b1;
        #1;
        chk("h_rs1_retry", bus.rs1_retry_pyro, 64'd0);
        tick();
        bus.claim_valid_pyri = 1'b0;
        #1;
        chk("h_rs1_data", bus.rs1_data_pyro, 64'h0000_0000_DEAD_BEEF);
        chk("h_rs1_blocked", bus.rs1_retry_pyro, 64'd1);
        tick();
        bus.rs1_valid_pyri = 1'b0;
        #1;
        chk("h_rs1_drained", bus.rs1_data_valid_pyro, 64'd0);

        // Response stall for three cycles, then reset in the middle of it.
        bus.rs1_addr_pyri  = 5'd7;
        bus.rs1_valid_pyri = 1'b1;
        tick();
        bus.rs1_data_retry_pyri = 1'b1;
        bus.wr_addr_pyri        = 64'd10;
        bus.wr_addr_valid_pyri  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("i_hold_valid", bus.rs1_data_valid_pyro, 64'd1);
            chk("i_hold_data", bus.rs1_data_pyro, 64'h11);
            chk("i_hold_retry", bus.rs1_retry_pyro, 64'd1);
            tick();
        end
        rst                    = 1'b1;
        bus.wr_addr_pyri       = 64'd11;
        bus.wr_data_pyri       = 64'h99;
        bus.wr_data_valid_pyri = 1'b1;
        bus.claim_addr_pyri    = 5'd5;
        bus.claim_valid_pyri   = 1'b1;
        #1;
        chk("i_rst_valid", bus.rs1_data_valid_pyro, 64'd0);
        chk("i_rst_data", bus.rs1_data_pyro, 64'd0);
        chk("i_rst_rs1_retry", bus.rs1_retry_pyro, 64'd0);
        chk("i_rst_claim_retry", bus.claim_retry_pyro, 64'd0);
        tick();
        idle();
        rst = 1'b0;

        // After reset: data-side buffering and retry, stale address discarded.
        bus.wr_data_pyri       = 64'hAA;
        bus.wr_data_valid_pyri = 1'b1;
        #1;
        chk("j_data_retry_0", bus.wr_data_retry_pyro, 64'd0);
        tick();
        bus.wr_data_pyri = 64'hBB;
        #1;
        chk("j_data_retry_1", bus.wr_data_retry_pyro, 64'd1);
        tick();
        bus.wr_addr_pyri       = 64'd12;
        bus.wr_addr_valid_pyri = 1'b1;
        #1;
        chk("j_addr_retry", bus.wr_addr_retry_pyro, 64'd0);
        chk("j_data_retry_2", bus.wr_data_retry_pyro, 64'd0);
        tick();
        idle();
        bus.wr_addr_pyri       = 64'd13;
        bus.wr_addr_valid_pyri = 1'b1;
        tick();
        idle();
        rd1("j_rd12", 5'd12, 64'hAA);
        rd1("j_rd13", 5'd13, 64'hBB);
        rd1("j_rd7", 5'd7, 64'd0);
        rd1("j_rd5", 5'd5, 64'd0);
        rd1("j_rd10", 5'd10, 64'd0);
        rd1("j_rd11", 5'd11, 64'd0);
        rd1("j_rd3", 5'd3, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pyrm_reg_file_block.md
PYRM_REG_FILE_BLOCK -- requirements
Module: pyrm_reg_file_block

Interface
REQ-001 SHALL have the ports below; handshake: transfer when valid=1 and retry=0 in the same cycle.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset_pyri  in  1  reset, asynchronous, active-high.
REQ-004 wr_addr_pyri / wr_addr_valid_pyri / wr_addr_retry_pyro  in/in/out  64/1/1  destination register from write-back; index = bits [4:0].
REQ-005 wr_data_pyri / wr_data_valid_pyri / wr_data_retry_pyro  in/in/out  64/1/1  write data from write-back.
REQ-006 claim_addr_pyri / claim_valid_pyri / claim_retry_pyro  in/in/out  5/1/1  decode reserves a destination register.
REQ-007 rs1_addr_pyri / rs1_valid_pyri / rs1_retry_pyro  in/in/out  5/1/1  source-1 read request; rs2_* identical for source 2.
REQ-008 rs1_data_pyro / rs1_data_valid_pyro / rs1_data_retry_pyri  out/out/in  64/1/1  source-1 read response; rs2_data_* identical.
REQ-009 Parameters: none; 32 registers x 64 bits fixed.

Function
REQ-010 Storage: 32x64 array; x0 reads 0 always; writes to x0 accepted and discarded.
REQ-011 Write pairing: one-entry addr buffer and one-entry data buffer; a write commits at the edge where an address and a data are both available (buffered or transferring this cycle), both then consumed.
REQ-012 Addr and data transferring in the same cycle with empty buffers SHALL commit at that edge (0-cycle buffering).
REQ-013 wr_addr_retry_pyro = addr buffer full and no data available this cycle; wr_data_retry_pyro symmetric.
REQ-014 Scoreboard: 32 busy bits; claim transfer sets busy[claim_addr] at next edge; commit clears busy[wr_addr[4:0]].
REQ-015 claim_retry_pyro = busy[claim_addr]=1 and no commit to that register this cycle; claim of x0 always accepted, busy[0] stays 0.
REQ-016 Same-cycle commit and claim on the same register: register written, busy ends 1 (claim wins).
REQ-017 Read: request accepted when source not busy, or a commit to that source occurs this cycle (bypass); response data registered, valid 1 cycle after acceptance.
REQ-018 Bypass: read accepted in a commit cycle to the same register returns the committed data, not the old array value.
REQ-019 rsN_retry_pyro = (busy[src] and no bypass) or (rsN_data_valid_pyro=1 and rsN_data_retry_pyri=1).
REQ-020 Response register holds data and valid stable while rsN_data_retry_pyri=1; clears valid on consumption with no new acceptance.
REQ-021 Back-to-back: a response consumed and a new request accepted in the same cycle yields a new response next cycle, no bubble.
REQ-022 rs1 and rs2 independent; both may read the same register same cycle.
REQ-023 Claim in cycle N blocks reads from cycle N+1; a read to that register in cycle N is accepted with the pre-claim value.
REQ-024 Upper bits wr_addr_pyri[63:5] ignored.

Reset
REQ-025 reset_pyri=1 clears immediately: all registers 0, busy bits 0, buffers empty, rsN_data_pyro=0, rsN_data_valid_pyro=0.
REQ-026 During reset all retry outputs SHALL be 0 and no transfer SHALL take effect; pending buffered halves and in-flight responses are discarded.
REQ-027 First edge after reset deassertion operates normally.

Verification
REQ-028 Write addr=5, data=0xDEAD_BEEF same cycle; read rs1=5 next cycle -> rs1_data_pyro=0xDEADBEEF one cycle later.
REQ-029 Addr=7 at cycle 0, data=0x11 at cycle 3 -> wr_addr_retry=1 cycles 1-2 for a second addr, commit at edge of cycle 3, x7=0x11.
REQ-030 Claim x9, read rs2=9 -> rs2_retry_pyro=1 until commit x9=0x42; read in commit cycle returns 0x42; busy[9]=0 after.
REQ-031 Claim x3 and commit x3=0x5 same cycle -> x3=0x5, subsequent claim x3 retried, read x3 retried.
REQ-032 Write x0=0xFFFF, claim x0 -> read x0 returns 0, never retried.
REQ-033 Hold rs1_data_retry_pyri=1 three cycles with response pending -> data/valid stable, rs1_retry_pyro=1; assert reset mid-hold -> valid=0, all registers 0.
